// File: rtl/block_loader_if.sv
// Handshake bundle between the pixel source, block_loader and the array-formatting stage.
// master = environment side (source + block consumer), slave = block_loader side.
interface block_loader_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sof;
  logic [DATA_W-1:0] output_block [64];
  logic              block_valid;
  logic              block_ready;

  modport master (
    output in_valid, in_data, in_sof, block_ready,
    input  in_ready, output_block, block_valid
  );

  modport slave (
    input  in_valid, in_data, in_sof, block_ready,
    output in_ready, output_block, block_valid
  );
endinterface

// File: rtl/block_loader.sv
// Collects 32-bit pixel words into 64-word (8x8 raster) blocks and presents them in parallel.
// Define BLOCK_LOADER_DOUBLE_BUFFER_EN for a ping-pong pair of buffers; default is a single buffer.
module block_loader #(
  parameter int DATA_W = 32
) (
  input  logic          clock,
  input  logic          reset_n,
  block_loader_if.slave bus,
  output logic [31:0]   block_count,
  output logic          sync_err
);

`ifdef BLOCK_LOADER_DOUBLE_BUFFER_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  // Buffers are filled and presented in strict alternation, so a selector just toggles.
  localparam logic SEL_STEP = (NB == 2);

  localparam logic [1:0] ST_EMPTY     = 2'd0;
  localparam logic [1:0] ST_FILLING   = 2'd1;
  localparam logic [1:0] ST_FULL      = 2'd2;
  localparam logic [1:0] ST_PRESENTED = 2'd3;

  logic [1:0]        buf_state     [NB];
  logic [1:0]        buf_state_nxt [NB];
  logic              fill_sel, fill_sel_nxt;
  logic              pres_sel, pres_sel_nxt;
  logic [5:0]        wr_idx;
  logic [5:0]        wr_addr;
  logic [DATA_W-1:0] mem [NB][64];

  logic in_ready_int;
  logic block_valid_int;
  logic accept;
  logic consume;
  logic resync;
  logic complete;

  // Both handshake outputs decode registered state only.
  assign in_ready_int    = (buf_state[fill_sel] == ST_EMPTY) ||
                           (buf_state[fill_sel] == ST_FILLING);
  assign block_valid_int = (buf_state[pres_sel] == ST_PRESENTED);

  assign bus.in_ready    = in_ready_int;
  assign bus.block_valid = block_valid_int;

  assign accept   = bus.in_valid && in_ready_int;
  assign consume  = block_valid_int && bus.block_ready;
  assign resync   = accept && bus.in_sof && (wr_idx != 6'd0);
  assign complete = accept && !resync && (wr_idx == 6'd63);
  assign wr_addr  = resync ? 6'd0 : wr_idx;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    buf_state_nxt = buf_state;
    fill_sel_nxt  = fill_sel;
    pres_sel_nxt  = pres_sel;

    if (consume) begin
      buf_state_nxt[pres_sel] = ST_EMPTY;
      pres_sel_nxt            = pres_sel ^ SEL_STEP;
    end

    if (accept) begin
      if (complete) begin
        buf_state_nxt[fill_sel] = ST_FULL;
        fill_sel_nxt            = fill_sel ^ SEL_STEP;
      end else begin
        buf_state_nxt[fill_sel] = ST_FILLING;
      end
    end

    // A full buffer at the head of the queue is presented on the same edge it becomes eligible.
    if (buf_state_nxt[pres_sel_nxt] == ST_FULL) begin
      buf_state_nxt[pres_sel_nxt] = ST_PRESENTED;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      for (int b = 0; b < NB; b++) begin
        buf_state[b] <= ST_EMPTY;
      end
      fill_sel    <= 1'b0;
      pres_sel    <= 1'b0;
      wr_idx      <= 6'd0;
      block_count <= 32'd0;
      sync_err    <= 1'b0;
    end else begin
      buf_state <= buf_state_nxt;
      fill_sel  <= fill_sel_nxt;
      pres_sel  <= pres_sel_nxt;
      if (accept) begin
        wr_idx <= resync ? 6'd1 : wr_idx + 6'd1;
      end
      if (consume) begin
        block_count <= block_count + 32'd1;
      end
      if (resync) begin
        sync_err <= 1'b1;
      end
    end
  end

  // NOTE: pixel storage is not reset; nothing is read from it unless its buffer is presented.
  always_ff @(posedge clock) begin
    if (accept) begin
      mem[fill_sel][wr_addr] <= bus.in_data;
    end
  end

  // Zero whenever nothing is presented, which also gives the all-zero block out of reset.
  always_comb begin
    for (int k = 0; k < 64; k++) begin
      bus.output_block[k] = block_valid_int ? mem[pres_sel][k] : '0;
    end
  end

endmodule

// File: tb/tb_block_loader.sv
// Self-checking bench for block_loader: table-driven vectors, corner sequences and a
// randomized run against a queue-based reference model. Honours BLOCK_LOADER_DOUBLE_BUFFER_EN.
module tb_block_loader;

`ifdef BLOCK_LOADER_DOUBLE_BUFFER_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif
  localparam int NB = DB ? 2 : 1;

  logic        clock   = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] block_count;
  logic        sync_err;

  int n_checks = 0;
  int n_fail   = 0;

  block_loader_if #(.DATA_W(32)) bus ();

  block_loader #(.DATA_W(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .bus         (bus),
    .block_count (block_count),
    .sync_err    (sync_err)
  );

  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: completed blocks queued word by word in completion order.
  logic [31:0] wq   [$];
  logic [31:0] part [$];
  int unsigned m_count;
  bit          m_err;

  function automatic bit m_ready();
    return (wq.size() / 64) < NB;
  endfunction

  function automatic bit m_valid();
    return wq.size() >= 64;
  endfunction

  task automatic model_reset();
    wq.delete();
    part.delete();
    m_count = 0;
    m_err   = 1'b0;
  endtask

  task automatic model_step(input bit acc, input bit cons, input bit sof, input logic [31:0] d);
    if (cons) begin
      for (int k = 0; k < 64; k++) void'(wq.pop_front());
      m_count++;
    end
    if (acc) begin
      if (sof && part.size() != 0) begin
        part.delete();
        m_err = 1'b1;
      end
      part.push_back(d);
      if (part.size() == 64) begin
        foreach (part[k]) wq.push_back(part[k]);
        part.delete();
      end
    end
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_block(input string name, input logic [31:0] base);
    int bad = 0;
    for (int k = 63; k >= 0; k--) if (bus.output_block[k] !== base + 32'(k)) bad = k;
    check($sformatf("%s[%0d]", name, bad), bus.output_block[bad], base + 32'(bad));
  endtask

  task automatic check_zero(input string name);
    int bad = 0;
    for (int k = 63; k >= 0; k--) if (bus.output_block[k] !== 32'd0) bad = k;
    check($sformatf("%s[%0d]", name, bad), bus.output_block[bad], 32'd0);
  endtask

  task automatic check_model(input string name);
    int bad = 0;
    check({name, "_in_ready"},    bus.in_ready,    m_ready());
    check({name, "_block_valid"}, bus.block_valid, m_valid());
    check({name, "_block_count"}, block_count,     m_count);
    check({name, "_sync_err"},    sync_err,        m_err);
    if (m_valid()) begin
      for (int k = 63; k >= 0; k--) if (bus.output_block[k] !== wq[k]) bad = k;
      check($sformatf("%s_block[%0d]", name, bad), bus.output_block[bad], wq[bad]);
    end
  endtask

  task automatic idle_inputs();
    bus.in_valid    = 1'b0;
    bus.in_data     = '0;
    bus.in_sof      = 1'b0;
    bus.block_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
  endtask

  // One clock cycle of stimulus; returns at 1 time unit after the edge.
  task automatic drive(input bit v, input logic [31:0] d, input bit sof, input bit rdy);
    bus.in_valid    = v;
    bus.in_data     = d;
    bus.in_sof      = sof;
    bus.block_ready = rdy;
    @(posedge clock);
    #1;
    idle_inputs();
  endtask

  typedef struct {
    int          cycles;
    bit          valid;
    bit          sof_first;
    logic [31:0] base;
    bit          rdy;
    bit          exp_ready;
    bit          exp_valid;
    int unsigned exp_count;
    bit          exp_err;
    logic [31:0] exp_e0;
    logic [31:0] exp_e9;
    logic [31:0] exp_e63;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int          acc_n;
    int          cyc;
    int          bub;
    bit          r;
    bit          v;
    bit          s;
    bit          br;
    bit          acc;
    bit          cons;
    logic [31:0] d;

    //        cyc v sof base    rdy  ready valid cnt err e0      e9      e63
    vecs[0] = '{63, 1, 1, 32'h0,   0,  1,  0, 0, 0, 32'h0,  32'h0,   32'h0};
    vecs[1] = '{1,  1, 0, 32'd63,  0, DB,  1, 0, 0, 32'h0,  32'd9,   32'd63};
    vecs[2] = '{1,  0, 0, 32'h0,   1,  1,  0, 1, 0, 32'h0,  32'h0,   32'h0};
    vecs[3] = '{20, 1, 1, 32'd100, 0,  1,  0, 1, 0, 32'h0,  32'h0,   32'h0};
    vecs[4] = '{1,  1, 1, 32'hAA,  0,  1,  0, 1, 1, 32'h0,  32'h0,   32'h0};
    vecs[5] = '{63, 1, 0, 32'h200, 0, DB,  1, 1, 1, 32'hAA, 32'h208, 32'h23E};
    vecs[6] = '{1,  0, 0, 32'h0,   1,  1,  0, 2, 1, 32'h0,  32'h0,   32'h0};

    idle_inputs();
    do_reset();

    check("reset_in_ready",    bus.in_ready,    1'b1);
    check("reset_block_valid", bus.block_valid, 1'b0);
    check("reset_block_count", block_count,     32'd0);
    check("reset_sync_err",    sync_err,        1'b0);
    check_zero("reset_output_block");

    // Table: first block, consume, then a resync block.
    for (int i = 0; i < 7; i++) begin
      for (int c = 0; c < vecs[i].cycles; c++) begin
        drive(vecs[i].valid, vecs[i].base + 32'(c), vecs[i].sof_first && (c == 0), vecs[i].rdy);
      end
      check($sformatf("vec%0d_in_ready", i),    bus.in_ready,    vecs[i].exp_ready);
      check($sformatf("vec%0d_block_valid", i), bus.block_valid, vecs[i].exp_valid);
      check($sformatf("vec%0d_block_count", i), block_count,     vecs[i].exp_count);
      check($sformatf("vec%0d_sync_err", i),    sync_err,        vecs[i].exp_err);
      if (vecs[i].exp_valid) begin
        check($sformatf("vec%0d_e0", i),  bus.output_block[0],  vecs[i].exp_e0);
        check($sformatf("vec%0d_e9", i),  bus.output_block[9],  vecs[i].exp_e9);
        check($sformatf("vec%0d_e63", i), bus.output_block[63], vecs[i].exp_e63);
      end
    end

    // Fill until back-pressure with no consumer, then poke data while stalled.
    do_reset();
    acc_n = 0;
    for (int c = 0; c < 400 && bus.in_ready; c++) begin
      drive(1'b1, 32'd1000 + 32'(acc_n), (acc_n % 64) == 0, 1'b0);
      acc_n++;
    end
    check("fill_accepts_before_stall", acc_n, 64 * NB);
    for (int c = 0; c < 3; c++) drive(1'b1, 32'hDEAD_BEEF, 1'b1, 1'b0);
    check("fill_stall_in_ready", bus.in_ready, 1'b0);
    check("fill_stall_sync_err", sync_err, 1'b0);
    check_block("fill_first_block", 32'd1000);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("fill_consume_count", block_count, 32'd1);
    check("fill_in_ready_after_consume", bus.in_ready, 1'b1);
    check("fill_valid_after_consume", bus.block_valid, DB);
    if (bus.block_valid) check_block("fill_second_block", 32'd1064);

    // Streaming with the consumer always ready.
    do_reset();
    acc_n = 0;
    cyc   = 0;
    bub   = 0;
    while (acc_n < 640 && cyc < 2000) begin
      r = bus.in_ready;
      drive(1'b1, 32'(acc_n), 1'b0, 1'b1);
      if (r) acc_n++;
      else bub++;
      cyc++;
    end
    check("stream_cycles", cyc, DB ? 640 : 649);
    check("stream_bubbles", bub, DB ? 0 : 9);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    check("stream_block_count", block_count, 32'd10);
    check("stream_block_valid", bus.block_valid, 1'b0);

    // Asynchronous reset while presenting, then mid-block, then a clean block.
    for (int i = 0; i < 5; i++) drive(1'b1, 32'(i), i == 0, 1'b0);
    drive(1'b1, 32'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 63; i++) drive(1'b1, 32'h300 + 32'(i), 1'b0, 1'b0);
    check("pre_areset_valid", bus.block_valid, 1'b1);
    check("pre_areset_sync_err", sync_err, 1'b1);
    #3 reset_n = 1'b0;
    #1;
    check("areset_present_valid", bus.block_valid, 1'b0);
    check("areset_present_count", block_count, 32'd0);
    check("areset_present_sync_err", sync_err, 1'b0);
    check_zero("areset_present_block");
    @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 10; i++) drive(1'b1, 32'h900 + 32'(i), i == 0, 1'b0);
    #3 reset_n = 1'b0;
    #1;
    check("areset_mid_valid", bus.block_valid, 1'b0);
    @(posedge clock);
    #2 reset_n = 1'b1;
    @(posedge clock);
    #1;
    for (int i = 0; i < 64; i++) drive(1'b1, 32'd500 + 32'(i), 1'b0, 1'b0);
    check("after_areset_valid", bus.block_valid, 1'b1);
    check("after_areset_sync_err", sync_err, 1'b0);
    check_block("after_areset_block", 32'd500);

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      check_model("rnd");
      v    = ($urandom_range(0, 9) < 8);
      s    = ($urandom_range(0, 99) < 3);
      br   = ($urandom_range(0, 2) == 0);
      d    = $urandom;
      acc  = v && m_ready();
      cons = br && m_valid();
      drive(v, d, s, br);
      model_step(acc, cons, s, d);
    end
    check_model("rnd_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
